// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : mips_pkg
//  Purpose  : Shared MIPS32 pipeline constants and register-index type.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Default datapath and register-index widths.
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Register index as carried by pipeline registers and the forwarding unit.
  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

  // Architectural $zero register.
  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/wb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : wb_mux
//  Purpose  : 2:1 write-back select (load data vs ALU result). Also used by
//             the forwarding unit so both agree on the write-back value.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_mux
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              memtoreg,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] wb_data
);

  // Select load data when memtoreg is set, otherwise the ALU result.
  always_comb begin
    wb_data = memtoreg ? read_data : alu_result;
  end

endmodule : wb_mux
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile
//  Purpose  : MIPS32 write-back stage and architectural register file.
//             32x32 array with hardwired $zero, two decode read ports with
//             optional same-cycle write-through bypass, a bypass-free debug
//             port and a committed-write counter.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              memtoreg,
  input  logic              regwrite,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_valid,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       commit_count
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  // Entry 0 is never written; reads of index 0 are forced to zero anyway,
  // keeping it in the array only simplifies indexing.
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [31:0]       commit_count_q;
  logic              commit;

  wb_mux #(
    .DATA_W (DATA_W)
  ) u_wb_mux (
    .memtoreg   (memtoreg),
    .read_data  (read_data),
    .alu_result (alu_result),
    .wb_data    (wb_data)
  );

  // A write-back is architecturally visible only to a non-zero register;
  // reset suppresses the actual commit but not the bypass indication.
  always_comb begin
    wb_valid = regwrite && (write_reg != ZERO_IDX);
    commit   = wb_valid && !reset;
  end

  // Register array: clear on reset, otherwise commit the write-back value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[write_reg] <= wb_data;
    end
  end

  // Committed-write counter; wraps naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      commit_count_q <= '0;
    end else if (commit) begin
      commit_count_q <= commit_count_q + 32'd1;
    end
  end

  assign commit_count = commit_count_q;

  // Decode read ports: $zero, then optional bypass, then stored value.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != ZERO_IDX) begin
      if (BYPASS && wb_valid && (rs_addr == write_reg)) begin
        rs_data = wb_data;
      end else begin
        rs_data = regs[rs_addr];
      end
    end
    if (rt_addr != ZERO_IDX) begin
      if (BYPASS && wb_valid && (rt_addr == write_reg)) begin
        rt_data = wb_data;
      end else begin
        rt_data = regs[rt_addr];
      end
    end
  end

  // Debug port shows committed state only, never the in-flight value.
  always_comb begin
    dbg_data = '0;
    if (dbg_addr != ZERO_IDX) begin
      dbg_data = regs[dbg_addr];
    end
  end

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_regfile
//  Purpose  : Self-checking bench for wb_regfile. Two instances share one
//             stimulus stream: one with bypass enabled, one without.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic        memtoreg;
  logic        regwrite;
  logic [31:0] read_data;
  logic [31:0] alu_result;
  logic [4:0]  write_reg;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  dbg_addr;

  logic [31:0] rs_data_b, rt_data_b, wb_data_b, dbg_data_b, count_b;
  logic        wb_valid_b;
  logic [31:0] rs_data_n, rt_data_n, wb_data_n, dbg_data_n, count_n;
  logic        wb_valid_n;

  always #5 clock = ~clock;

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_byp (
    .clock(clock), .reset(reset), .memtoreg(memtoreg), .regwrite(regwrite),
    .read_data(read_data), .alu_result(alu_result), .write_reg(write_reg),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data_b),
    .rt_data(rt_data_b), .wb_data(wb_data_b), .wb_valid(wb_valid_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_b), .commit_count(count_b)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nob (
    .clock(clock), .reset(reset), .memtoreg(memtoreg), .regwrite(regwrite),
    .read_data(read_data), .alu_result(alu_result), .write_reg(write_reg),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data_n),
    .rt_data(rt_data_n), .wb_data(wb_data_n), .wb_valid(wb_valid_n),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_n), .commit_count(count_n)
  );

  // Output selectors used by scoreboard entries.
  localparam int SEL_RS_B  = 0;
  localparam int SEL_RT_B  = 1;
  localparam int SEL_WB_B  = 2;
  localparam int SEL_VAL_B = 3;
  localparam int SEL_DBG_B = 4;
  localparam int SEL_CNT_B = 5;
  localparam int SEL_RS_N  = 6;
  localparam int SEL_RT_N  = 7;
  localparam int SEL_DBG_N = 8;
  localparam int SEL_CNT_N = 9;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  int          num_checks = 0;
  int          num_errors = 0;

  // Reference state
  logic [31:0] model_regs [32];
  logic [31:0] model_cnt_b;
  logic [31:0] model_cnt_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_RS_B:  return rs_data_b;
      SEL_RT_B:  return rt_data_b;
      SEL_WB_B:  return wb_data_b;
      SEL_VAL_B: return {31'd0, wb_valid_b};
      SEL_DBG_B: return dbg_data_b;
      SEL_CNT_B: return count_b;
      SEL_RS_N:  return rs_data_n;
      SEL_RT_N:  return rt_data_n;
      SEL_DBG_N: return dbg_data_n;
      default:   return count_n;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_entry_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] addr, input bit byp,
                                             input bit valid, input logic [4:0] wr,
                                             input logic [31:0] wbd);
    if (addr == 5'd0) return 32'd0;
    if (byp && valid && addr == wr) return wbd;
    return model_regs[addr];
  endfunction

  // One clock cycle: drive at negedge, check combinational outputs,
  // then advance the reference model across the rising edge.
  task automatic cycle(input string tag, input bit rst, input bit rw, input bit m2r,
                       input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] wr,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg,
                       input bit do_check);
    logic [31:0] wbd;
    bit          valid;
    @(negedge clock);
    reset = rst; regwrite = rw; memtoreg = m2r; read_data = rd; alu_result = alu;
    write_reg = wr; rs_addr = rs; rt_addr = rt; dbg_addr = dbg;
    wbd   = m2r ? rd : alu;
    valid = rw && (wr != 5'd0);
    if (do_check) begin
      expect_out({tag, ".rs_b"},  SEL_RS_B,  model_read(rs, 1'b1, valid, wr, wbd));
      expect_out({tag, ".rt_b"},  SEL_RT_B,  model_read(rt, 1'b1, valid, wr, wbd));
      expect_out({tag, ".wb"},    SEL_WB_B,  wbd);
      expect_out({tag, ".valid"}, SEL_VAL_B, {31'd0, valid});
      expect_out({tag, ".dbg_b"}, SEL_DBG_B, model_read(dbg, 1'b0, valid, wr, wbd));
      expect_out({tag, ".cnt_b"}, SEL_CNT_B, model_cnt_b);
      expect_out({tag, ".rs_n"},  SEL_RS_N,  model_read(rs, 1'b0, valid, wr, wbd));
      expect_out({tag, ".rt_n"},  SEL_RT_N,  model_read(rt, 1'b0, valid, wr, wbd));
      expect_out({tag, ".dbg_n"}, SEL_DBG_N, model_read(dbg, 1'b0, valid, wr, wbd));
      expect_out({tag, ".cnt_n"}, SEL_CNT_N, model_cnt_n);
      #1;
      drain();
    end
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_cnt_b = 32'd0;
      model_cnt_n = 32'd0;
    end else if (valid) begin
      model_regs[wr] = wbd;
      model_cnt_b    = model_cnt_b + 32'd1;
      model_cnt_n    = model_cnt_n + 32'd1;
    end
  endtask

  // Stop a runaway simulation with a reported failure.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    model_cnt_b = 32'd0;
    model_cnt_n = 32'd0;

    // Bring both instances out of an unknown power-up state.
    cycle("init", 1, 0, 0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0);

    // Reset dominates a presented write; nothing reaches register 3.
    cycle("rst_wr", 1, 1, 0, 32'd0, 32'hDEAD_BEEF, 5'd3, 5'd3, 5'd3, 5'd3, 1);
    cycle("rst_rd", 0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd3, 5'd3, 1);

    // ALU write-back with bypass, then committed read.
    cycle("alu_wr", 0, 1, 0, 32'h0BAD_0BAD, 32'h0000_1234, 5'd8, 5'd8, 5'd1, 5'd8, 1);
    cycle("alu_rd", 0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd8, 5'd8, 5'd8, 1);

    // Load write-back selects read_data.
    cycle("ld_wr", 0, 1, 1, 32'hCAFE_0001, 32'hFFFF_FFFF, 5'd9, 5'd9, 5'd9, 5'd9, 1);
    cycle("ld_rd", 0, 0, 1, 32'h1111_1111, 32'h2222_2222, 5'd0, 5'd9, 5'd8, 5'd9, 1);

    // $zero protection: no commit, no count, reads stay 0.
    cycle("zero_wr", 0, 1, 0, 32'd0, 32'h5555_5555, 5'd0, 5'd0, 5'd0, 5'd0, 1);
    cycle("zero_rd", 0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1);

    // Bypass disable: regs[4]=7, then write 9 while reading rt=4.
    cycle("r4_7", 0, 1, 0, 32'd0, 32'd7, 5'd4, 5'd0, 5'd0, 5'd4, 1);
    cycle("r4_9", 0, 1, 0, 32'd0, 32'd9, 5'd4, 5'd8, 5'd4, 5'd4, 1);
    cycle("r4_rd", 0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd4, 5'd4, 5'd4, 1);

    // Both ports on write_reg; back-to-back writes to the same index.
    cycle("same_a", 0, 1, 0, 32'd0, 32'hAAAA_0001, 5'd17, 5'd17, 5'd17, 5'd17, 1);
    cycle("same_b", 0, 1, 1, 32'hAAAA_0002, 32'd0, 5'd17, 5'd17, 5'd17, 5'd17, 1);
    cycle("same_rd", 0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd17, 5'd17, 5'd17, 1);

    // regwrite=0 with a live mux: wb_data tracks, nothing commits.
    cycle("idle", 0, 0, 1, 32'h7777_7777, 32'h8888_8888, 5'd5, 5'd5, 5'd5, 5'd5, 1);

    // Randomised traffic.
    for (int n = 0; n < 60; n++) begin
      cycle("rand", 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1);
    end

    // Mid-stream reset discards the in-flight write.
    cycle("mid_rst", 1, 1, 0, 32'd0, 32'h1357_9BDF, 5'd12, 5'd12, 5'd9, 5'd12, 1);
    cycle("post_rst", 0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd12, 5'd9, 5'd9, 1);

    // Counter wrap: preload the counter of the bypass instance.
    @(negedge clock);
    force dut_byp.commit_count_q = 32'hFFFF_FFFF;
    #1;
    release dut_byp.commit_count_q;
    model_cnt_b = 32'hFFFF_FFFF;
    cycle("wrap_wr", 0, 1, 0, 32'd0, 32'h0000_0042, 5'd21, 5'd21, 5'd0, 5'd21, 1);
    cycle("wrap_rd", 0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd21, 5'd0, 5'd21, 1);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule : tb_wb_regfile
`default_nettype wire

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file of the MIPS32 pipeline. It consumes the MEM/WB pipeline register outputs and selects the write-back value (load data or ALU result). It commits that value into a 32×32 register file with `$zero` hardwired, and serves the two decode-stage read ports with same-cycle write-through bypass. It also exports the write-back value and a committed-write counter for the forwarding unit and debug.

## Interface
Parameters:
- `DATA_W`, default 32, register and data width.
- `ADDR_W`, default 5, register index width (2^ADDR_W registers).
- `BYPASS`, default 1. When 1, a read of the register being written this cycle returns the new value. When 0, it returns the stored value.

Ports:
- `clock` input, 1: clock; all state updates on its rising edge.
- `reset` input, 1: reset, synchronous, active-high.
- `memtoreg` input, 1: write-back select; 1 = `read_data`, 0 = `alu_result`.
- `regwrite` input, 1: commit enable for this cycle's write-back.
- `read_data` input, DATA_W: load data from MEM/WB.
- `alu_result` input, DATA_W: ALU result from MEM/WB.
- `write_reg` input, ADDR_W: destination register index from MEM/WB.
- `rs_addr` input, ADDR_W: read port A index (decode stage).
- `rt_addr` input, ADDR_W: read port B index (decode stage).
- `rs_data` output, DATA_W: read port A data, combinational.
- `rt_data` output, DATA_W: read port B data, combinational.
- `wb_data` output, DATA_W: selected write-back value, combinational, for the forwarding unit.
- `wb_valid` output, 1: `regwrite && write_reg != 0`, combinational.
- `dbg_addr` input, ADDR_W: debug read index.
- `dbg_data` output, DATA_W: stored value at `dbg_addr`; no bypass.
- `commit_count` output, 32: number of committed writes since reset.

## Operation
- `wb_data` is `read_data` when `memtoreg` = 1, otherwise `alu_result`.
- Commit condition is `regwrite && write_reg != 0 && !reset`.
  - On commit, `regs[write_reg] <= wb_data` at the rising edge.
  - On the same edge, `commit_count` increments by 1 and wraps from 2^32−1 to 0.
- Writes to register 0 are discarded. `regwrite` = 1 with `write_reg` = 0 does not increment `commit_count`.
- Read ports A and B behave identically and independently:
  - Index 0 always returns 0.
  - Else, if BYPASS = 1, `wb_valid` = 1 and the index equals `write_reg`, the port returns `wb_data`.
  - Else the port returns `regs[index]`.
- `dbg_data` returns `regs[dbg_addr]`, and 0 for index 0. It never uses the bypass.
- `memtoreg` is don't-care when `regwrite` = 0. `wb_data` still tracks the mux.

## Timing
- Reset, synchronous:
  - At an edge with `reset` = 1, all registers and `commit_count` become 0.
  - Any write presented on that edge is dropped; reset wins.
  - Reset asserted mid-stream discards the in-flight write-back.
  - After reset, `rs_data`, `rt_data` and `dbg_data` read 0 until the first commit, except that the bypass may return `wb_data` in the cycle a commit is presented.
- Write latency:
  - The array is updated one edge after presentation.
  - With BYPASS = 1, the read ports see the value in the presentation cycle, so a decode-stage read in the same cycle as the write-back gets the new value.
  - With BYPASS = 0, the new value is seen in the cycle after the edge.
- Read latency: zero cycles on all ports; pure combinational from address and state.
- Simultaneous events:
  - Both read ports may address `write_reg`; both bypass.
  - `rs_addr` = `rt_addr` is legal.
  - Consecutive writes to the same index: the last one wins, with one write per edge.
- No stalls or backpressure; one write-back per cycle maximum.

## Structure
- Shared package `mips_pkg` holds:
  - `REG_ZERO` = 5'd0.
  - Default `DATA_W` / `ADDR_W` constants.
  - Register-index typedef `reg_idx_t`, used by the pipeline registers and the forwarding unit.
- One sub-module, `wb_mux`: the 2:1 write-back select. It is reused by the forwarding unit.
- The register array, bypass compare and `commit_count` stay in `wb_regfile`.

## Test plan
- Reset then read:
  - Stimulus: assert `reset` 1 cycle with `regwrite` = 1, `write_reg` = 3, `alu_result` = 32'hDEAD_BEEF; then read `rs_addr` = 3.
  - Required response: 0 after reset; `commit_count` = 0.
- ALU write-back:
  - Stimulus: `regwrite` = 1, `memtoreg` = 0, `write_reg` = 8, `alu_result` = 32'h0000_1234.
  - Required response: same-cycle `rs_data` (addr 8) = 32'h0000_1234 via bypass; after the edge, `dbg_data`[8] = 32'h0000_1234; `commit_count` = 1.
- Load write-back:
  - Stimulus: `memtoreg` = 1, `read_data` = 32'hCAFE_0001, `alu_result` = 32'hFFFF_FFFF, `write_reg` = 9.
  - Required response: `regs[9]` = 32'hCAFE_0001; `wb_data` shows 32'hCAFE_0001.
- $zero protection:
  - Stimulus: `regwrite` = 1, `write_reg` = 0, `alu_result` = 32'h5555_5555.
  - Required response: `rs_data`/`rt_data`/`dbg_data` at index 0 stay 0; `wb_valid` = 0; `commit_count` unchanged.
- Bypass disable:
  - Stimulus: BYPASS = 0; `regs[4]` = 7; write 9 to register 4 while `rt_addr` = 4.
  - Required response: `rt_data` = 7 in the presentation cycle and 9 in the next cycle.
- Counter wrap:
  - Stimulus: force `commit_count` to 32'hFFFF_FFFF, then commit one write.
  - Required response: `commit_count` = 0.
